// File: rtl/ring_osc_bank_pkg.sv
// Shared types and default parameters for the ring oscillator bank.
package ring_osc_bank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } osc_state_t;

  localparam int CH_DEF         = 4;
  localparam int CNT_W_DEF      = 8;
  localparam int EC_W_DEF       = 16;
  localparam int RELOAD_RST_DEF = 1;

endpackage

// File: rtl/ring_osc_bank_if.sv
// Control/status bundle for the oscillator bank: run requests, reload values,
// polarity in; oscillator outputs, busy flags and edge counters out.
interface ring_osc_bank_if
  import ring_osc_bank_pkg::*;
#(
  parameter int CH    = CH_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int EC_W  = EC_W_DEF
) ();

  logic [CH-1:0]       en;
  logic                load;
  logic [CH*CNT_W-1:0] half_period;
  logic [CH-1:0]       inv_pol;
  logic [CH-1:0]       osc_out;
  logic [CH-1:0]       busy;
  logic [CH*EC_W-1:0]  edge_cnt;

  modport master (
    output en, load, half_period, inv_pol,
    input  osc_out, busy, edge_cnt
  );

  modport slave (
    input  en, load, half_period, inv_pol,
    output osc_out, busy, edge_cnt
  );

endinterface

// File: rtl/ring_osc_bank_chan.sv
// One oscillator channel: IDLE/RUN/DRAIN FSM, half-period counter, reload, edge counter.
// Latency: phase toggles exactly reload edges after the previous toggle or RUN entry.
// Backpressure: none; en is a level request, a running half-period always completes at rest.
module ring_osc_bank_chan
  import ring_osc_bank_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int EC_W       = EC_W_DEF,
  parameter int RELOAD_RST = RELOAD_RST_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] half_period,
  output logic             phase,
  output logic             busy,
  output logic [EC_W-1:0]  edge_cnt
);

  osc_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] reload;
  logic             terminal;

  // reload is never 0, so reload-1 cannot wrap
  assign terminal = (cnt >= reload - CNT_W'(1));
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      phase    <= 1'b0;
      cnt      <= '0;
      reload   <= CNT_W'(RELOAD_RST);
      edge_cnt <= '0;
    end else begin
      if (load) begin
        reload <= (half_period == '0) ? CNT_W'(1) : half_period;
      end

      case (state)
        ST_IDLE: begin
          phase <= 1'b0;
          cnt   <= '0;
          if (en) begin
            state    <= ST_RUN;
            edge_cnt <= '0;
          end
        end

        ST_RUN, ST_DRAIN: begin
          if (state == ST_RUN && !en && !phase) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (terminal) begin
            // with en low the phase here is always 1, so this toggle lands at rest
            phase <= ~phase;
            cnt   <= '0;
            if (!(&edge_cnt)) begin
              edge_cnt <= edge_cnt + EC_W'(1);
            end
            state <= en ? ST_RUN : ST_IDLE;
          end else begin
            cnt   <= cnt + CNT_W'(1);
            state <= en ? ST_RUN : ST_DRAIN;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/ring_osc_bank.sv
// Bank of CH independent programmable square-wave generators with polarity and edge counts.
// Latency: busy rises one edge after en; osc_out follows registered phase combinationally.
// Backpressure: none; load is a single-cycle strobe shared by all channels.
module ring_osc_bank
  import ring_osc_bank_pkg::*;
#(
  parameter int CH         = CH_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int EC_W       = EC_W_DEF,
  parameter int RELOAD_RST = RELOAD_RST_DEF
) (
  input logic            clk,
  input logic            rst_n,
  ring_osc_bank_if.slave bus
);

  logic [CH-1:0]      phase_v;
  logic [CH-1:0]      busy_v;
  logic [CH*EC_W-1:0] ecnt_v;

  for (genvar i = 0; i < CH; i++) begin : g_chan
    ring_osc_bank_chan #(
      .CNT_W      (CNT_W),
      .EC_W       (EC_W),
      .RELOAD_RST (RELOAD_RST)
    ) u_chan (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (bus.en[i]),
      .load        (bus.load),
      .half_period (bus.half_period[i*CNT_W +: CNT_W]),
      .phase       (phase_v[i]),
      .busy        (busy_v[i]),
      .edge_cnt    (ecnt_v[i*EC_W +: EC_W])
    );
  end

  // polarity is applied after the register so it never counts as an edge
  assign bus.osc_out  = phase_v ^ bus.inv_pol;
  assign bus.busy     = busy_v;
  assign bus.edge_cnt = ecnt_v;

endmodule

// File: tb/tb_ring_osc_bank.sv
// Self-checking bench for ring_osc_bank: vector tables per channel plus hand sequences.
module tb_ring_osc_bank;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  ring_osc_bank_if #(.CH(4), .CNT_W(8), .EC_W(16)) bus_a ();
  ring_osc_bank_if #(.CH(1), .CNT_W(8), .EC_W(4))  bus_b ();

  ring_osc_bank #(.CH(4), .CNT_W(8), .EC_W(16), .RELOAD_RST(1)) u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  ring_osc_bank #(.CH(1), .CNT_W(8), .EC_W(4), .RELOAD_RST(1)) u_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  typedef struct {
    logic        osc;
    logic        busy;
    logic [15:0] ec;
  } exp_t;

  typedef struct {
    logic        en;
    logic        load;
    logic [7:0]  hp;
    logic        osc;
    logic        busy;
    logic [15:0] ec;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[$];
  int          ntest = 0;
  int          nfail = 0;
  logic [31:0] hp_all;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    ntest++;
    if (act !== expv) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic sb_cmp(input string tag, input logic osc, input logic busy, input logic [15:0] ec);
    exp_t e;
    if (sb.size() == 0) begin
      ntest++;
      nfail++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, " osc"},  32'(osc),  32'(e.osc));
      chk({tag, " busy"}, 32'(busy), 32'(e.busy));
      chk({tag, " ecnt"}, 32'(ec),   32'(e.ec));
    end
  endtask

  task automatic add(input int en, input int load, input int hp, input int osc, input int busy, input int ec);
    vecs.push_back('{1'(en), 1'(load), 8'(hp), 1'(osc), 1'(busy), 16'(ec)});
  endtask

  task automatic run_vecs(input int ch, input string tag);
    for (int r = 0; r < vecs.size(); r++) begin
      bus_a.en[ch] = vecs[r].en;
      bus_a.load   = vecs[r].load;
      if (vecs[r].load) hp_all[ch*8 +: 8] = vecs[r].hp;
      bus_a.half_period = hp_all;
      sb.push_back('{vecs[r].osc ^ bus_a.inv_pol[ch], vecs[r].busy, vecs[r].ec});
      tick;
      sb_cmp($sformatf("%s r%0d", tag, r), bus_a.osc_out[ch], bus_a.busy[ch],
             bus_a.edge_cnt[ch*16 +: 16]);
    end
    bus_a.load = 1'b0;
    vecs.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n             = 1'b0;
    hp_all            = '0;
    bus_a.en          = '0;
    bus_a.load        = 1'b0;
    bus_a.half_period = '0;
    bus_a.inv_pol     = 4'b0101;
    bus_b.en          = '0;
    bus_b.load        = 1'b0;
    bus_b.half_period = '0;
    bus_b.inv_pol     = 1'b1;

    // reset values before any clock, under a clock, and after release
    for (int p = 0; p < 3; p++) begin
      if (p == 0) #1;
      else tick;
      chk($sformatf("rst%0d osc", p),  32'(bus_a.osc_out), 32'(4'b0101));
      chk($sformatf("rst%0d busy", p), 32'(bus_a.busy), 32'(0));
      for (int c = 0; c < 4; c++)
        chk($sformatf("rst%0d ecnt%0d", p, c), 32'(bus_a.edge_cnt[c*16 +: 16]), 32'(0));
      chk($sformatf("rst%0d b osc", p), 32'(bus_b.osc_out), 32'(1));
      if (p == 1) rst_n = 1'b1;
    end
    bus_a.inv_pol = 4'b0000;
    bus_b.inv_pol = 1'b0;

    // ch0: half-period 3, twenty cycles of run
    hp_all[7:0]       = 8'd3;
    bus_a.half_period = hp_all;
    bus_a.load        = 1'b1;
    tick;
    bus_a.load  = 1'b0;
    bus_a.en[0] = 1'b1;
    for (int j = 0; j < 20; j++) begin
      sb.push_back('{1'((j / 3) % 2), 1'b1, 16'(j / 3)});
      tick;
      sb_cmp($sformatf("ch0 j%0d", j), bus_a.osc_out[0], bus_a.busy[0], bus_a.edge_cnt[15:0]);
    end
    bus_a.en[0] = 1'b0;
    sb.push_back('{1'b0, 1'b0, 16'd6});
    tick;
    sb_cmp("ch0 stop", bus_a.osc_out[0], bus_a.busy[0], bus_a.edge_cnt[15:0]);

    // ch1: en dropped one cycle after rising toggle, drains to rest
    add(1, 1, 4, 0, 1, 0);
    for (int k = 0; k < 3; k++) add(1, 0, 0, 0, 1, 0);
    add(1, 0, 0, 1, 1, 1);
    for (int k = 0; k < 3; k++) add(0, 0, 0, 1, 1, 1);
    add(0, 0, 0, 0, 0, 2);
    add(0, 0, 0, 0, 0, 2);
    run_vecs(1, "ch1");

    // ch2: re-request while draining keeps period and busy
    add(1, 1, 4, 0, 1, 0);
    for (int k = 0; k < 3; k++) add(1, 0, 0, 0, 1, 0);
    add(1, 0, 0, 1, 1, 1);
    add(0, 0, 0, 1, 1, 1);
    add(1, 0, 0, 1, 1, 1);
    add(1, 0, 0, 1, 1, 1);
    add(1, 0, 0, 0, 1, 2);
    for (int k = 0; k < 3; k++) add(1, 0, 0, 0, 1, 2);
    add(1, 0, 0, 1, 1, 3);
    run_vecs(2, "ch2");

    // ch3: reload 10, shrink to 4 at cnt 6, then half_period 0 acts as 1
    add(1, 1, 10, 0, 1, 0);
    for (int k = 0; k < 6; k++) add(1, 0, 0, 0, 1, 0);
    add(1, 1, 4, 0, 1, 0);
    for (int k = 0; k < 4; k++) add(1, 0, 0, 1, 1, 1);
    for (int k = 0; k < 4; k++) add(1, 0, 0, 0, 1, 2);
    add(1, 0, 0, 1, 1, 3);
    add(1, 1, 0, 1, 1, 3);
    add(1, 0, 0, 0, 1, 4);
    add(1, 0, 0, 1, 1, 5);
    add(1, 0, 0, 0, 1, 6);
    run_vecs(3, "ch3");

    // polarity flips output without a clock and without counting
    bus_a.inv_pol = 4'b1000;
    #1;
    chk("inv_pol osc3", 32'(bus_a.osc_out[3]), 32'(1));
    chk("inv_pol ecnt3", 32'(bus_a.edge_cnt[63:48]), 32'(6));

    // narrow counter saturation at reload 1
    bus_b.en = 1'b1;
    for (int j = 0; j < 40; j++) begin
      sb.push_back('{1'(j % 2), 1'b1, 16'((j < 15) ? j : 15)});
      tick;
      sb_cmp($sformatf("b j%0d", j), bus_b.osc_out[0], bus_b.busy[0], 16'(bus_b.edge_cnt));
    end

    // asynchronous reset in the middle of a cycle with channels running
    bus_a.inv_pol = 4'b0110;
    bus_b.inv_pol = 1'b1;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst osc", 32'(bus_a.osc_out), 32'(4'b0110));
    chk("arst busy", 32'(bus_a.busy), 32'(0));
    for (int c = 0; c < 4; c++)
      chk($sformatf("arst ecnt%0d", c), 32'(bus_a.edge_cnt[c*16 +: 16]), 32'(0));
    chk("arst b osc", 32'(bus_b.osc_out), 32'(1));
    chk("arst b busy", 32'(bus_b.busy), 32'(0));
    chk("arst b ecnt", 32'(bus_b.edge_cnt), 32'(0));
    bus_a.en = '0;
    bus_b.en = '0;
    tick;
    rst_n = 1'b1;
    tick;

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule
